// File: rtl/dmem_responder.sv
// dmem_responder: target end of the core's dmem_* interface.
// Word-organised SRAM model with byte-lane writes, a fixed number of wait
// states between accept and response, and a one-cycle response beat that
// flags out-of-range and misaligned accesses.
// Optional feature macro: DMEM_STATS_EN adds saturating read/write/error
// event counters (stat_rd, stat_wr, stat_err).
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8010_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_valid,
    output logic        dmem_ready,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wen,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_rvalid,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_rd,
    output logic [31:0] stat_wr,
    output logic [31:0] stat_err
`endif
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [3:0]      wait_cnt;
    logic [3:0]      wait_cnt_next;
    logic            accept;
    logic            enter_resp;

    logic [31:0]     req_addr_p0;
    logic [3:0]      req_wen_p0;
    logic [31:0]     req_wdata_p0;

    logic [31:0]     cur_addr;
    logic [3:0]      cur_wen;
    logic [31:0]     cur_wdata;
    logic [31:0]     cur_off;
    logic            cur_err;
    logic [IDX_W-1:0] cur_idx;

    logic [31:0]     mem [DEPTH_WORDS];

    assign dmem_ready = (state == IDLE);
    assign accept     = dmem_valid && dmem_ready;
    assign enter_resp = (next_state == RESP);

    // Next-state and wait-counter logic
    always_comb begin
        next_state    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        next_state    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Capture the request on accept; data path, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr_p0  <= dmem_addr;
            req_wen_p0   <= dmem_wen;
            req_wdata_p0 <= dmem_wdata;
        end
    end

    // With zero wait states the array access happens on the accept edge itself,
    // so the live inputs are used in IDLE and the captured request otherwise.
    always_comb begin
        cur_addr  = (state == IDLE) ? dmem_addr  : req_addr_p0;
        cur_wen   = (state == IDLE) ? dmem_wen   : req_wen_p0;
        cur_wdata = (state == IDLE) ? dmem_wdata : req_wdata_p0;
        cur_off   = cur_addr - BASE_ADDR;
        cur_err   = (cur_off >= SPAN) || (cur_addr[1:0] != 2'b00);
        cur_idx   = cur_off[IDX_W+1:2];
    end

    // Byte-lane array write on the edge entering RESP; never while in reset
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && !cur_err && (cur_wen != 4'b0000)) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wen[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response beat: read data and error sampled entering RESP, cleared after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_rvalid <= 1'b0;
            dmem_rdata  <= 32'd0;
            dmem_err    <= 1'b0;
        end else begin
            dmem_rvalid <= enter_resp;
            if (enter_resp) begin
                dmem_err   <= cur_err;
                dmem_rdata <= (!cur_err && (cur_wen == 4'b0000)) ? mem[cur_idx] : 32'd0;
            end else begin
                dmem_err   <= 1'b0;
                dmem_rdata <= 32'd0;
            end
        end
    end

`ifdef DMEM_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating event counters, bumped once per response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd  <= 32'd0;
            stat_wr  <= 32'd0;
            stat_err <= 32'd0;
        end else if (enter_resp) begin
            if (cur_err) begin
                stat_err <= sat_inc(stat_err);
            end else if (cur_wen == 4'b0000) begin
                stat_rd <= sat_inc(stat_rd);
            end else begin
                stat_wr <= sat_inc(stat_wr);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES of
// 0, 1 and 3 (slots 0, 1, 2) share one clock; each has its own reset and inputs.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_v  [3];
    logic        valid_v  [3];
    logic        ready_v  [3];
    logic [31:0] addr_v   [3];
    logic [3:0]  wen_v    [3];
    logic [31:0] wdata_v  [3];
    logic        rvalid_v [3];
    logic [31:0] rdata_v  [3];
    logic        err_v    [3];
`ifdef DMEM_STATS_EN
    logic [31:0] st_rd_v  [3];
    logic [31:0] st_wr_v  [3];
    logic [31:0] st_err_v [3];
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n_v[0]), .dmem_valid(valid_v[0]), .dmem_ready(ready_v[0]),
        .dmem_addr(addr_v[0]), .dmem_wen(wen_v[0]), .dmem_wdata(wdata_v[0]),
        .dmem_rvalid(rvalid_v[0]), .dmem_rdata(rdata_v[0]), .dmem_err(err_v[0])
`ifdef DMEM_STATS_EN
        , .stat_rd(st_rd_v[0]), .stat_wr(st_wr_v[0]), .stat_err(st_err_v[0])
`endif
    );

    dmem_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n_v[1]), .dmem_valid(valid_v[1]), .dmem_ready(ready_v[1]),
        .dmem_addr(addr_v[1]), .dmem_wen(wen_v[1]), .dmem_wdata(wdata_v[1]),
        .dmem_rvalid(rvalid_v[1]), .dmem_rdata(rdata_v[1]), .dmem_err(err_v[1])
`ifdef DMEM_STATS_EN
        , .stat_rd(st_rd_v[1]), .stat_wr(st_wr_v[1]), .stat_err(st_err_v[1])
`endif
    );

    dmem_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n_v[2]), .dmem_valid(valid_v[2]), .dmem_ready(ready_v[2]),
        .dmem_addr(addr_v[2]), .dmem_wen(wen_v[2]), .dmem_wdata(wdata_v[2]),
        .dmem_rvalid(rvalid_v[2]), .dmem_rdata(rdata_v[2]), .dmem_err(err_v[2])
`ifdef DMEM_STATS_EN
        , .stat_rd(st_rd_v[2]), .stat_wr(st_wr_v[2]), .stat_err(st_err_v[2])
`endif
    );

    // Drive one request on slot s and collect its response. With hold set, valid
    // stays high during WAIT while address/strobes/data change to other values.
    // lat counts falling edges from the accept edge to the rvalid cycle (-1 = none).
    // rdy_ok: ready high before accept and low until the response beat.
    // clean: the cycle after the beat is idle with zeroed rdata/err and ready high.
    task automatic xact(input int s, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, input bit hold,
                        output logic [31:0] rd, output logic e, output int lat,
                        output bit rdy_ok, output bit clean);
        bit got;
        @(negedge clk);
        valid_v[s] = 1'b1; addr_v[s] = a; wen_v[s] = w; wdata_v[s] = d;
        rdy_ok = (ready_v[s] === 1'b1);
        @(posedge clk);
        lat = 0; got = 1'b0; rd = 32'd0; e = 1'b1;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (ready_v[s] !== 1'b0) rdy_ok = 1'b0;
            if (rvalid_v[s] === 1'b1) begin
                got = 1'b1; rd = rdata_v[s]; e = err_v[s]; valid_v[s] = 1'b0;
            end else if (hold) begin
                addr_v[s] = a + 32'd4; wen_v[s] = ~w; wdata_v[s] = ~d;
            end else begin
                valid_v[s] = 1'b0;
            end
        end
        valid_v[s] = 1'b0;
        if (!got) lat = -1;
        @(negedge clk);
        clean = (rvalid_v[s] === 1'b0) && (rdata_v[s] === 32'd0) &&
                (err_v[s] === 1'b0) && (ready_v[s] === 1'b1);
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic e; int lat; bit rok, cln; int n;
        // still in power-on reset here
        n_cmp++; if (ready_v[1] !== 1'b1 || rvalid_v[1] !== 1'b0 || rdata_v[1] !== 32'd0 || err_v[1] !== 1'b0) begin
            n_fail++; $display("FAIL por_state: ready=%b rvalid=%b rdata=%h err=%b want 1 0 0 0", ready_v[1], rvalid_v[1], rdata_v[1], err_v[1]); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n_v[i] = 1'b1;
        xact(1, 32'h8010_0020, 4'hF, 32'hA5A5_0F0F, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL rst_setup_err: got %b want 0", e); end
        // read, then assert reset mid-cycle while the response beat is up
        @(negedge clk);
        valid_v[1] = 1'b1; addr_v[1] = 32'h8010_0020; wen_v[1] = 4'h0;
        @(posedge clk);
        n = 0;
        do begin @(negedge clk); valid_v[1] = 1'b0; n++; end while (rvalid_v[1] !== 1'b1 && n < 10);
        n_cmp++; if (rdata_v[1] !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL rst_pre_rdata: got %h want a5a50f0f", rdata_v[1]); end
        #2 rst_n_v[1] = 1'b0;
        #1;
        n_cmp++; if (rvalid_v[1] !== 1'b0 || rdata_v[1] !== 32'd0 || err_v[1] !== 1'b0 || ready_v[1] !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: rvalid=%b rdata=%h err=%b ready=%b want 0 0 0 1", rvalid_v[1], rdata_v[1], err_v[1], ready_v[1]); end
        @(negedge clk);
        rst_n_v[1] = 1'b1;
        @(negedge clk);
        n_cmp++; if (rvalid_v[1] !== 1'b0) begin n_fail++; $display("FAIL post_reset_rvalid: got %b want 0", rvalid_v[1]); end
    endtask

    task automatic test_basic_rw();
        logic [31:0] rd; logic e; int lat; bit rok, cln;
        xact(1, 32'h8010_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL w1_wr_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'd0 || e !== 1'b0) begin n_fail++; $display("FAIL w1_wr_resp: rdata=%h err=%b want 0 0", rd, e); end
        n_cmp++; if (!(rok && cln)) begin n_fail++; $display("FAIL w1_wr_handshake: ready_ok=%b clean=%b want 1 1", rok, cln); end
        xact(1, 32'h8010_0010, 4'h0, 32'h0, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL w1_rd_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin n_fail++; $display("FAIL w1_rd_data: rdata=%h err=%b want deadbeef 0", rd, e); end
        n_cmp++; if (!(rok && cln)) begin n_fail++; $display("FAIL w1_rd_handshake: ready_ok=%b clean=%b want 1 1", rok, cln); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic e; int lat; bit rok, cln;
        xact(1, 32'h8010_0010, 4'b0010, 32'h0000_5500, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL lane_wr_err: got %b want 0", e); end
        xact(1, 32'h8010_0010, 4'h0, 32'h0, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (rd !== 32'hDEAD_55EF) begin n_fail++; $display("FAIL lane_rd_data: got %h want dead55ef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat; bit rok, cln;
        xact(1, 32'h8010_0000, 4'hF, 32'h1122_3344, 1'b0, rd, e, lat, rok, cln);
        xact(1, 32'h8010_0FFC, 4'hF, 32'h5566_7788, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL last_word_err: got %b want 0", e); end
        xact(1, 32'h8010_1000, 4'h0, 32'h0, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_above_range: err=%b rdata=%h want 1 0", e, rd); end
        xact(1, 32'h800F_FFFC, 4'h0, 32'h0, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_below_base: err=%b rdata=%h want 1 0", e, rd); end
        xact(1, 32'h8010_0002, 4'hF, 32'hFFFF_FFFF, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_misaligned_wr: err=%b rdata=%h want 1 0", e, rd); end
        n_cmp++; if (lat !== 2 || !cln) begin n_fail++; $display("FAIL err_beat_shape: lat=%0d clean=%b want 2 1", lat, cln); end
        xact(1, 32'h8010_1000, 4'hF, 32'h0000_0000, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_range_wr: err=%b want 1", e); end
        xact(1, 32'h8010_0000, 4'h0, 32'h0, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (rd !== 32'h1122_3344 || e !== 1'b0) begin n_fail++; $display("FAIL word0_intact: rdata=%h err=%b want 11223344 0", rd, e); end
        xact(1, 32'h8010_0FFC, 4'h0, 32'h0, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (rd !== 32'h5566_7788 || e !== 1'b0) begin n_fail++; $display("FAIL last_word_intact: rdata=%h err=%b want 55667788 0", rd, e); end
    endtask

    task automatic test_wait0();
        logic [31:0] rd; logic e; int lat; bit rok, cln;
        xact(0, 32'h8010_0040, 4'hF, 32'hCAFE_F00D, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (lat !== 1 || e !== 1'b0) begin n_fail++; $display("FAIL w0_wr: lat=%0d err=%b want 1 0", lat, e); end
        xact(0, 32'h8010_0040, 4'h0, 32'h0, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL w0_rd_latency: got %0d want 1", lat); end
        n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL w0_rd_data: got %h want cafef00d", rd); end
        n_cmp++; if (!(rok && cln)) begin n_fail++; $display("FAIL w0_handshake: ready_ok=%b clean=%b want 1 1", rok, cln); end
    endtask

    task automatic test_wait3_hold();
        logic [31:0] rd; logic e; int lat; bit rok, cln;
        xact(2, 32'h8010_0040, 4'hF, 32'h0F1E_2D3C, 1'b1, rd, e, lat, rok, cln);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL w3_wr_latency: got %0d want 4", lat); end
        n_cmp++; if (!(rok && cln)) begin n_fail++; $display("FAIL w3_wr_handshake: ready_ok=%b clean=%b want 1 1", rok, cln); end
        xact(2, 32'h8010_0040, 4'h0, 32'h0, 1'b1, rd, e, lat, rok, cln);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL w3_rd_latency: got %0d want 4", lat); end
        n_cmp++; if (rd !== 32'h0F1E_2D3C || e !== 1'b0) begin n_fail++; $display("FAIL w3_rd_data: rdata=%h err=%b want 0f1e2d3c 0", rd, e); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic e; int lat; bit rok, cln; int seen;
        xact(2, 32'h8010_0020, 4'hF, 32'h0BAD_F00D, 1'b0, rd, e, lat, rok, cln);
        @(negedge clk);
        valid_v[2] = 1'b1; addr_v[2] = 32'h8010_0020; wen_v[2] = 4'hF; wdata_v[2] = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        valid_v[2] = 1'b0;
        n_cmp++; if (ready_v[2] !== 1'b0) begin n_fail++; $display("FAIL riw_in_wait: ready=%b want 0", ready_v[2]); end
        #2 rst_n_v[2] = 1'b0;
        #1;
        n_cmp++; if (ready_v[2] !== 1'b1) begin n_fail++; $display("FAIL riw_ready: got %b want 1", ready_v[2]); end
        @(negedge clk);
        rst_n_v[2] = 1'b1;
        seen = 0;
        repeat (8) begin @(negedge clk); if (rvalid_v[2] === 1'b1) seen++; end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL riw_no_rvalid: got %0d beats want 0", seen); end
`ifdef DMEM_STATS_EN
        n_cmp++; if (st_wr_v[2] !== 32'd0) begin n_fail++; $display("FAIL riw_stat_wr: got %0d want 0", st_wr_v[2]); end
`endif
        xact(2, 32'h8010_0020, 4'h0, 32'h0, 1'b0, rd, e, lat, rok, cln);
        n_cmp++; if (rd !== 32'h0BAD_F00D || e !== 1'b0) begin n_fail++; $display("FAIL riw_prior_word: rdata=%h err=%b want 0badf00d 0", rd, e); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n_v[i] = 1'b0; valid_v[i] = 1'b0; addr_v[i] = 32'd0; wen_v[i] = 4'd0; wdata_v[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_rw();
        test_byte_lanes();
        test_errors();
        test_wait0();
        test_wait3_hold();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
